// File: rtl/rot_tile_addr_gen_if.sv
// Command bus between the tile address generator and the burst engine.
//
// Handshake: the master raises O_AG_CMD_VALID with ADDR/WRITE/LAST/BYTES
// stable; a command is transferred on every clock edge where VALID and
// I_AG_CMD_READY are both high. While VALID is high and READY is low the
// master holds every payload field unchanged. READY may toggle freely.
//
// Signals:
//   O_AG_CMD_VALID  command valid
//   I_AG_CMD_READY  command accepted when VALID && READY
//   O_AG_CMD_ADDR   row burst start byte address
//   O_AG_CMD_WRITE  0 = read burst, 1 = write burst
//   O_AG_CMD_LAST   last row of the current tile
//   O_AG_CMD_BYTES  burst length in bytes
interface rot_tile_addr_gen_if #(
  parameter int ADDR_W = 32
);
  logic              O_AG_CMD_VALID;
  logic              I_AG_CMD_READY;
  logic [ADDR_W-1:0] O_AG_CMD_ADDR;
  logic              O_AG_CMD_WRITE;
  logic              O_AG_CMD_LAST;
  logic [15:0]       O_AG_CMD_BYTES;

  modport master (
    output O_AG_CMD_VALID, O_AG_CMD_ADDR, O_AG_CMD_WRITE, O_AG_CMD_LAST, O_AG_CMD_BYTES,
    input  I_AG_CMD_READY
  );

  modport slave (
    input  O_AG_CMD_VALID, O_AG_CMD_ADDR, O_AG_CMD_WRITE, O_AG_CMD_LAST, O_AG_CMD_BYTES,
    output I_AG_CMD_READY
  );
endinterface

// File: rtl/rot_tile_addr_gen.sv
// Tile address generator for the image rotation engine.
// Walks the source image in TILE x TILE tiles (tx outer, ty inner). For each
// tile it issues TILE row-burst reads, then TILE row-burst writes at the
// tile's rotated destination position. Pixel reordering is done downstream.
//
// Ports:
//   I_AG_HCLK, I_AG_RESET        clock, synchronous active-high reset
//   I_AG_START                   start pulse, sampled in IDLE only
//   I_AG_HEIGHT/WIDTH            source dimensions in pixels
//   I_AG_DEGREES/DIRECTION       rotation (0/90/180/270), 1 = clockwise
//   I_AG_SRC/DST_BASE, _PITCH    byte base addresses and row strides
//   cmd                          command bus (master side)
//   O_AG_BUSY                    high in READ/WRITE/DONE
//   O_AG_DONE                    one-cycle pulse after the last write
//   O_AG_ERR                     one-cycle pulse on START with illegal dims
//   O_AG_OUT_H/OUT_W             padded, rotated output dimensions
//   O_AG_DBG_STATE               current FSM state
module rot_tile_addr_gen #(
  parameter int TILE_LG2 = 3,   // must be >= 1
  parameter int BPP      = 3,
  parameter int ADDR_W   = 32,
  parameter int DIM_W    = 16,
  parameter int MAX_DIM  = 16384
) (
  input  logic              I_AG_HCLK,
  input  logic              I_AG_RESET,
  input  logic              I_AG_START,
  input  logic [DIM_W-1:0]  I_AG_HEIGHT,
  input  logic [DIM_W-1:0]  I_AG_WIDTH,
  input  logic [1:0]        I_AG_DEGREES,
  input  logic              I_AG_DIRECTION,
  input  logic [ADDR_W-1:0] I_AG_SRC_BASE,
  input  logic [ADDR_W-1:0] I_AG_DST_BASE,
  input  logic [ADDR_W-1:0] I_AG_SRC_PITCH,
  input  logic [ADDR_W-1:0] I_AG_DST_PITCH,
  rot_tile_addr_gen_if.master cmd,
  output logic              O_AG_BUSY,
  output logic              O_AG_DONE,
  output logic              O_AG_ERR,
  output logic [DIM_W-1:0]  O_AG_OUT_H,
  output logic [DIM_W-1:0]  O_AG_OUT_W,
  output logic [1:0]        O_AG_DBG_STATE
);
  localparam int TILE = 1 << TILE_LG2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [ADDR_W-1:0]   TB     = ADDR_W'(TILE * BPP);  // tile width in bytes
  localparam logic [TILE_LG2-1:0] R_LAST = '1;

  logic [1:0]          state_q;
  logic                valid_q, write_q, last_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DIM_W-1:0]    out_h_q, out_w_q;
  logic [TILE_LG2-1:0] r_q;
  logic [DIM_W-1:0]    tx_q, ty_q, nht_m1_q, nwt_m1_q;
  logic [ADDR_W-1:0]   sp_q, dp_q, inner_q, outer_q;
  // Read pointers: rd_col_q = column origin, rd_ptr_q = current/next read row.
  // The read row pointer simply keeps stepping by the pitch down a column,
  // since tile ty+1 starts exactly one row after the last row of tile ty.
  logic [ADDR_W-1:0]   rd_col_q, rd_ptr_q;
  // Write pointers: column start tile, current tile origin, current row.
  logic [ADDR_W-1:0]   wr_col_q, wr_tile_q, wr_ptr_q;

  // ---- START-time setup (padding, legality, rotation deltas) -------------
  logic              dims_bad;
  logic [DIM_W-1:0]  nh, nw, nh_m, nw_m;
  logic [1:0]        eff;
  logic [ADDR_W-1:0] rs, x_h, x_w, y_h, y_w, init_off, inner_d, outer_d;

  assign dims_bad = (I_AG_HEIGHT == '0) || (I_AG_WIDTH == '0) ||
                    (I_AG_HEIGHT > DIM_W'(MAX_DIM)) || (I_AG_WIDTH > DIM_W'(MAX_DIM));
  // Legal dims never overflow DIM_W when rounded up.
  assign nh   = (I_AG_HEIGHT + DIM_W'(TILE - 1)) & ~DIM_W'(TILE - 1);
  assign nw   = (I_AG_WIDTH  + DIM_W'(TILE - 1)) & ~DIM_W'(TILE - 1);
  assign nh_m = nh - DIM_W'(TILE);
  assign nw_m = nw - DIM_W'(TILE);
  // Counter-clockwise swaps 90 and 270.
  assign eff  = (!I_AG_DIRECTION && I_AG_DEGREES[0]) ? (I_AG_DEGREES ^ 2'b10) : I_AG_DEGREES;
  // Far-edge offsets are formed once per run; the command path only adds.
  assign rs   = I_AG_DST_PITCH << TILE_LG2;
  assign x_h  = ADDR_W'(nh_m) * ADDR_W'(BPP);
  assign x_w  = ADDR_W'(nw_m) * ADDR_W'(BPP);
  assign y_h  = ADDR_W'(nh_m) * I_AG_DST_PITCH;
  assign y_w  = ADDR_W'(nw_m) * I_AG_DST_PITCH;

  // Destination tile of (tx,ty): start offset of column tx=0, step per ty
  // (inner) and step per tx (outer).
  always_comb begin
    init_off = '0;
    inner_d  = rs;
    outer_d  = TB;
    case (eff)
      2'd1:    begin init_off = x_h;       inner_d = -TB; outer_d = rs;  end
      2'd2:    begin init_off = y_h + x_w; inner_d = -rs; outer_d = -TB; end
      2'd3:    begin init_off = y_w;       inner_d = TB;  outer_d = -rs; end
      default: begin init_off = '0;        inner_d = rs;  outer_d = TB;  end
    endcase
  end

  // ---- Command path -------------------------------------------------------
  logic                fire;
  logic [TILE_LG2-1:0] r_nxt;
  logic [ADDR_W-1:0]   rd_ptr_nxt, wr_ptr_nxt, wr_tile_nxt, rd_col_nxt, wr_col_nxt;

  assign fire        = valid_q && cmd.I_AG_CMD_READY;
  assign r_nxt       = r_q + TILE_LG2'(1);
  assign rd_ptr_nxt  = rd_ptr_q + sp_q;
  assign wr_ptr_nxt  = wr_ptr_q + dp_q;
  assign wr_tile_nxt = wr_tile_q + inner_q;
  assign rd_col_nxt  = rd_col_q + TB;
  assign wr_col_nxt  = wr_col_q + outer_q;

  always_ff @(posedge I_AG_HCLK) begin
    if (I_AG_RESET) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      out_h_q  <= '0;
      out_w_q  <= '0;
      r_q      <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      nht_m1_q <= '0;
      nwt_m1_q <= '0;
      sp_q     <= '0;
      dp_q     <= '0;
      inner_q  <= '0;
      outer_q  <= '0;
      rd_col_q <= '0;
      rd_ptr_q <= '0;
      wr_col_q <= '0;
      wr_tile_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (I_AG_START) begin
            if (dims_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= ST_READ;
              valid_q   <= 1'b1;
              write_q   <= 1'b0;
              last_q    <= 1'b0;
              addr_q    <= I_AG_SRC_BASE;
              out_h_q   <= eff[0] ? nw : nh;
              out_w_q   <= eff[0] ? nh : nw;
              r_q       <= '0;
              tx_q      <= '0;
              ty_q      <= '0;
              nht_m1_q  <= (nh >> TILE_LG2) - DIM_W'(1);
              nwt_m1_q  <= (nw >> TILE_LG2) - DIM_W'(1);
              sp_q      <= I_AG_SRC_PITCH;
              dp_q      <= I_AG_DST_PITCH;
              inner_q   <= inner_d;
              outer_q   <= outer_d;
              rd_col_q  <= I_AG_SRC_BASE;
              rd_ptr_q  <= I_AG_SRC_BASE;
              wr_col_q  <= I_AG_DST_BASE + init_off;
              wr_tile_q <= I_AG_DST_BASE + init_off;
              wr_ptr_q  <= I_AG_DST_BASE + init_off;
            end
          end
        end
        ST_READ: begin
          if (fire) begin
            rd_ptr_q <= rd_ptr_nxt;
            if (r_q == R_LAST) begin
              state_q <= ST_WRITE;
              write_q <= 1'b1;
              last_q  <= 1'b0;
              r_q     <= '0;
              addr_q  <= wr_ptr_q;
            end else begin
              r_q    <= r_nxt;
              last_q <= (r_nxt == R_LAST);
              addr_q <= rd_ptr_nxt;
            end
          end
        end
        ST_WRITE: begin
          if (fire) begin
            if (r_q != R_LAST) begin
              r_q      <= r_nxt;
              last_q   <= (r_nxt == R_LAST);
              wr_ptr_q <= wr_ptr_nxt;
              addr_q   <= wr_ptr_nxt;
            end else begin
              r_q    <= '0;
              last_q <= 1'b0;
              if (ty_q != nht_m1_q) begin
                state_q   <= ST_READ;
                write_q   <= 1'b0;
                ty_q      <= ty_q + DIM_W'(1);
                wr_tile_q <= wr_tile_nxt;
                wr_ptr_q  <= wr_tile_nxt;
                addr_q    <= rd_ptr_q;
              end else if (tx_q != nwt_m1_q) begin
                state_q   <= ST_READ;
                write_q   <= 1'b0;
                tx_q      <= tx_q + DIM_W'(1);
                ty_q      <= '0;
                rd_col_q  <= rd_col_nxt;
                rd_ptr_q  <= rd_col_nxt;
                addr_q    <= rd_col_nxt;
                wr_col_q  <= wr_col_nxt;
                wr_tile_q <= wr_col_nxt;
                wr_ptr_q  <= wr_col_nxt;
              end else begin
                state_q <= ST_DONE;
                valid_q <= 1'b0;
                write_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;  // ST_DONE lasts one cycle
      endcase
    end
  end

  assign cmd.O_AG_CMD_VALID = valid_q;
  assign cmd.O_AG_CMD_ADDR  = addr_q;
  assign cmd.O_AG_CMD_WRITE = write_q;
  assign cmd.O_AG_CMD_LAST  = last_q;
  assign cmd.O_AG_CMD_BYTES = 16'(TILE * BPP);
  assign O_AG_BUSY      = (state_q != ST_IDLE);
  assign O_AG_DONE      = (state_q == ST_DONE);
  assign O_AG_ERR       = err_q;
  assign O_AG_OUT_H     = out_h_q;
  assign O_AG_OUT_W     = out_w_q;
  assign O_AG_DBG_STATE = state_q;
endmodule

// File: tb/tb_rot_tile_addr_gen.sv
module tb_rot_tile_addr_gen;
  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;
  localparam int TILE   = 8;
  localparam int BPP    = 3;
  localparam int W      = ADDR_W + 2;  // {addr, write, last}

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] w;
    logic [1:0]  deg;
    logic        dir;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] sp;
    logic [31:0] dp;
    logic [1:0]  mode;   // 0 ready=1, 1 toggle then stall, 2 random
    logic [15:0] oh;
    logic [15:0] ow;
  } vec_t;

  // ---- clock / reset ------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [DIM_W-1:0]  h_i = '0, w_i = '0;
  logic [1:0]        deg_i = '0;
  logic              dir_i = 1'b0;
  logic [ADDR_W-1:0] src_i = '0, dst_i = '0, sp_i = '0, dp_i = '0;
  logic              busy, done, err;
  logic [DIM_W-1:0]  out_h, out_w;
  logic [1:0]        dbg_state;

  rot_tile_addr_gen_if #(.ADDR_W(ADDR_W)) cmd_if ();

  rot_tile_addr_gen dut (
    .I_AG_HCLK      (clk),
    .I_AG_RESET     (rst),
    .I_AG_START     (start),
    .I_AG_HEIGHT    (h_i),
    .I_AG_WIDTH     (w_i),
    .I_AG_DEGREES   (deg_i),
    .I_AG_DIRECTION (dir_i),
    .I_AG_SRC_BASE  (src_i),
    .I_AG_DST_BASE  (dst_i),
    .I_AG_SRC_PITCH (sp_i),
    .I_AG_DST_PITCH (dp_i),
    .cmd            (cmd_if),
    .O_AG_BUSY      (busy),
    .O_AG_DONE      (done),
    .O_AG_ERR       (err),
    .O_AG_OUT_H     (out_h),
    .O_AG_OUT_W     (out_w),
    .O_AG_DBG_STATE (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[9];
  int ready_mode = 0;
  int rk = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int h, input int w, input int deg, input int dir,
                              input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] sp, input logic [31:0] dp,
                              input int mode, input int oh, input int ow);
    vec_t v;
    v.h = 16'(h); v.w = 16'(w); v.deg = 2'(deg); v.dir = 1'(dir);
    v.src = src; v.dst = dst; v.sp = sp; v.dp = dp;
    v.mode = 2'(mode); v.oh = 16'(oh); v.ow = 16'(ow);
    return v;
  endfunction

  // Reference model: direct (multiplying) address formula per tile/row.
  task automatic push_expected(input vec_t v);
    int nht, nwt, eff, dy, dx;
    logic [31:0] a;
    nht = (int'(v.h) + TILE - 1) / TILE;
    nwt = (int'(v.w) + TILE - 1) / TILE;
    eff = int'(v.deg);
    if (!v.dir && (eff == 1 || eff == 3)) eff = 4 - eff;
    for (int tx = 0; tx < nwt; tx++) begin
      for (int ty = 0; ty < nht; ty++) begin
        for (int r = 0; r < TILE; r++) begin
          a = v.src + 32'((ty * TILE + r)) * v.sp + 32'(tx * TILE * BPP);
          exp_q.push_back({a, 1'b0, (r == TILE - 1)});
        end
        case (eff)
          0:       begin dy = ty;           dx = tx;           end
          1:       begin dy = tx;           dx = nht - 1 - ty; end
          2:       begin dy = nht - 1 - ty; dx = nwt - 1 - tx; end
          default: begin dy = nwt - 1 - tx; dx = ty;           end
        endcase
        for (int r = 0; r < TILE; r++) begin
          a = v.dst + 32'((dy * TILE + r)) * v.dp + 32'(dx * TILE * BPP);
          exp_q.push_back({a, 1'b1, (r == TILE - 1)});
        end
      end
    end
  endtask

  // ---- ready driver -------------------------------------------------------
  initial begin
    cmd_if.I_AG_CMD_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: cmd_if.I_AG_CMD_READY = 1'b1;
        1: begin
          cmd_if.I_AG_CMD_READY = (rk < 20) ? ~rk[0] : (rk >= 25);
          rk++;
        end
        default: cmd_if.I_AG_CMD_READY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---- scoreboard monitor -------------------------------------------------
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_cmd = '0;
  always @(negedge clk) begin
    logic [W-1:0] cur, expv;
    cur = {cmd_if.O_AG_CMD_ADDR, cmd_if.O_AG_CMD_WRITE, cmd_if.O_AG_CMD_LAST};
    if (!rst) begin
      if (stall_prev)
        chk("stall_hold", {cmd_if.O_AG_CMD_VALID, cur}, {1'b1, prev_cmd});
      if (cmd_if.O_AG_CMD_VALID && cmd_if.I_AG_CMD_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cmd_extra got=%0h expected=none", cur);
        end else begin
          expv = exp_q.pop_front();
          if (cur !== expv) begin
            failures++;
            $display("FAIL cmd got=%0h expected=%0h", cur, expv);
          end
        end
      end
      stall_prev = cmd_if.O_AG_CMD_VALID && !cmd_if.I_AG_CMD_READY;
      prev_cmd = cur;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---- driver tasks -------------------------------------------------------
  task automatic drive_start(input vec_t v);
    @(posedge clk);
    #1;
    h_i = v.h; w_i = v.w; deg_i = v.deg; dir_i = v.dir;
    src_i = v.src; dst_i = v.dst; sp_i = v.sp; dp_i = v.dp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs change mid-run; the DUT must keep using the latched values.
    h_i = 16'($urandom_range(1, 100)); w_i = 16'($urandom_range(1, 100));
    deg_i = ~deg_i; dir_i = ~dir_i;
    src_i = $urandom; dst_i = $urandom; sp_i = $urandom; dp_i = $urandom;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n, ncmd, limit;
    bit got_done;
    ready_mode = int'(v.mode);
    rk = 0;
    push_expected(v);
    ncmd = exp_q.size();
    limit = 4 * ncmd + 200;
    drive_start(v);
    n = 0;
    got_done = 0;
    while (!got_done && n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({nm, "_valid_rise"}, {busy, cmd_if.O_AG_CMD_VALID}, 2'b11);
      if (done) got_done = 1;
    end
    chk({nm, "_done_seen"}, 64'(got_done), 64'd1);
    if (v.mode == 0) chk({nm, "_done_cycle"}, 64'(n), 64'(ncmd + 1));
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_out_h"}, 64'(out_h), 64'(v.oh));
    chk({nm, "_out_w"}, 64'(out_w), 64'(v.ow));
    exp_q.delete();
    @(negedge clk);
    chk({nm, "_idle_after"}, {done, busy, cmd_if.O_AG_CMD_VALID}, 3'b000);
  endtask

  task automatic err_case(input int h, input int w, input int oh, input int ow, input string nm);
    vec_t v;
    ready_mode = 0;
    v = mk(h, w, 0, 1, 32'h0, 32'h0, 32'd24, 32'd24, 0, 0, 0);
    drive_start(v);
    @(negedge clk);
    chk({nm, "_err_pulse"}, {err, busy, cmd_if.O_AG_CMD_VALID}, 3'b100);
    @(negedge clk);
    chk({nm, "_err_clear"}, {err, busy}, 2'b00);
    chk({nm, "_out_hold"}, {out_h, out_w}, {16'(oh), 16'(ow)});
  endtask

  // ---- main sequence ------------------------------------------------------
  initial begin
    int n;
    bit saw_done;
    vecs[0] = mk(8, 8, 0, 1, 32'h1000, 32'h8000, 32'd24, 32'd24, 0, 8, 8);
    vecs[1] = mk(16, 8, 1, 1, 32'h1000, 32'h8000, 32'd24, 32'd48, 0, 8, 16);
    vecs[2] = mk(16, 8, 1, 0, 32'h1000, 32'h8000, 32'd24, 32'd48, 0, 8, 16);
    vecs[3] = mk(16, 8, 3, 1, 32'h1000, 32'h8000, 32'd24, 32'd48, 0, 8, 16);
    vecs[4] = mk(16, 16, 2, 1, 32'h0, 32'h40000, 32'd48, 32'd48, 0, 16, 16);
    vecs[5] = mk(10, 5, 0, 1, 32'h2000, 32'h9000, 32'd24, 32'd24, 0, 16, 8);
    vecs[6] = mk(10, 5, 3, 0, 32'h100, 32'h200, 32'd40, 32'd64, 1, 8, 16);
    vecs[7] = mk(24, 17, 2, 0, 32'hFFFF_FF00, 32'hFFFF_F000, 32'h1234, 32'h777, 2, 24, 24);
    vecs[8] = mk(8, 16384, 1, 1, 32'h0, 32'h1000_0000, 32'd49152, 32'd24, 0, 16384, 8);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {cmd_if.O_AG_CMD_VALID, cmd_if.O_AG_CMD_WRITE, cmd_if.O_AG_CMD_LAST,
                       busy, done, err}, 6'b0);
    chk("reset_addr", 64'(cmd_if.O_AG_CMD_ADDR), 64'd0);
    chk("reset_out", {out_h, out_w}, 32'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    chk("cmd_bytes", 64'(cmd_if.O_AG_CMD_BYTES), 64'(TILE * BPP));

    run_vec(vecs[0], "v0_deg0");
    err_case(0, 8, 8, 8, "err_h0");
    err_case(8, 0, 8, 8, "err_w0");
    err_case(8, 16385, 8, 8, "err_wbig");
    err_case(16385, 8, 8, 8, "err_hbig");
    for (int i = 1; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Ignored START mid-run, then reset during the WRITE phase.
    ready_mode = 0;
    push_expected(mk(16, 16, 0, 1, 32'h3000, 32'h5000, 32'd48, 32'd48, 0, 16, 16));
    drive_start(mk(16, 16, 0, 1, 32'h3000, 32'h5000, 32'd48, 32'd48, 0, 16, 16));
    @(posedge clk);
    #1;
    h_i = 16'd8; w_i = 16'd8; deg_i = 2'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!cmd_if.O_AG_CMD_WRITE && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_write", {cmd_if.O_AG_CMD_VALID, cmd_if.O_AG_CMD_WRITE}, 2'b11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_valid_drop", {cmd_if.O_AG_CMD_VALID, busy, dbg_state}, 4'b0000);
    exp_q.delete();
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run_vec(vecs[0], "v0_after_abort");

    run_vec(vecs[8], "v8_maxw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
